uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter PARITY, default "NONE", one of "NONE"/"ODD"/"EVEN".
REQ-004 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port RXD  input  1  serial line, asynchronous to clk, idle high.
REQ-008 SHALL have port rx_data  output  DATA_WIDTH  last received word, LSB first on line.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse marking a completed frame.
REQ-010 SHALL have port rx_parity_err  output  1  parity mismatch of the last frame, valid with rx_valid.
REQ-011 SHALL have port rx_frame_err  output  1  stop bit sampled low in the last frame, valid with rx_valid.

Function
REQ-012 SHALL pass RXD through a 2-flop synchronizer, both flops reset to 1, before any use.
REQ-013 SHALL define BIT_CYC = CLK_FREQ/BAUD_RATE (integer division) and HALF_CYC = BIT_CYC/2.
REQ-014 SHALL receive frame format: start(0), DATA_WIDTH data bits LSB first, one parity slot, one stop(1); the parity slot is present for every PARITY value, matching the team's uart_tx.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARI, STOP, DONE.
REQ-016 IDLE: SHALL leave IDLE only on a synchronized 1->0 transition; a line held low never re-triggers.
REQ-017 START: SHALL sample HALF_CYC cycles after the detected edge; a sample of 1 is a false start -> IDLE with no flags or pulse; a sample of 0 -> DATA.
REQ-018 DATA/PARI/STOP: SHALL take each subsequent sample exactly BIT_CYC cycles after the previous one (mid-bit).
REQ-019 DATA: SHALL shift samples into a DATA_WIDTH register, sample k into bit k, and move to PARI after DATA_WIDTH samples; the bit counter SHALL clear on entry to START.
REQ-020 PARI: for "EVEN", error = sample != XOR(data); for "ODD", error = sample != ~XOR(data); for "NONE", sample ignored and error = 0.
REQ-021 STOP: frame_err = ~sample; SHALL go to DONE regardless of the sampled value.
REQ-022 DONE: SHALL last one cycle, load rx_data and both error flags, pulse rx_valid high for exactly that cycle, then return to IDLE.
REQ-023 SHALL assert rx_valid on the clock cycle after the stop-bit sample.
REQ-024 rx_data and error flags SHALL hold their values until the next DONE.
REQ-025 After a frame error with the line still low, SHALL wait in IDLE until the line returns high and then falls again.
REQ-026 A falling edge during DONE SHALL be detected in the IDLE cycle that follows, with no frame lost when frames are back-to-back.
REQ-027 The baud counter SHALL be wide enough for BIT_CYC, SHALL be held at 0 in IDLE, and SHALL restart at 0 on entry to START.

Reset
REQ-028 On arstn low, SHALL immediately set: FSM IDLE, counters 0, synchronizer 1, rx_data 0, rx_valid 0, rx_parity_err 0, rx_frame_err 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; after release, reception SHALL restart only on a new falling edge.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state encodings, the parity-mode constants, and the ceil-log2 width function shared with uart_tx.
REQ-031 The synchronizer SHALL be a sub-module named sync_2ff (parameter reset value); all other logic stays in uart_rx.

Verification (CLK_FREQ=50_000_000, BAUD_RATE=9600 -> BIT_CYC=5208; DATA_WIDTH=8)
REQ-032 PARITY="EVEN", drive frame 0xA5 with parity 0 and stop 1 -> one rx_valid pulse, rx_data=0xA5, both error flags 0.
REQ-033 PARITY="ODD", drive 0x3C with parity 0 (wrong) -> rx_valid pulse, rx_data=0x3C, rx_parity_err=1.
REQ-034 Stop bit forced 0 on 0x55, line then held low for 3 bit times -> rx_frame_err=1, exactly one rx_valid pulse, no second frame until the line goes high and then low.
REQ-035 Low glitch of 1000 cycles on an idle line -> no rx_valid; next valid frame 0x0F received correctly.
REQ-036 uart_tx to uart_rx loopback at matching parameters, 256 back-to-back words 0x00..0xFF, all PARITY modes -> every word received in order with no errors.
REQ-037 arstn pulsed low during data bit 4 -> outputs at reset values; the following frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity modes and
// the width helper used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARI,
        STOP,
        DONE
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    // ceil(log2(v)), never below 1 so it can size a vector directly
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both stages reset to RST_VAL so an idle-high line looks idle out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic arstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH bits LSB first, one parity slot, one stop.
// Bits are sampled mid-bit by a baud counter restarted on every sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int    CLK_FREQ   = 50_000_000,
    parameter int    BAUD_RATE  = 9600,
    parameter string PARITY     = "NONE",
    parameter int    DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  RXD,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

    localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CW       = clog2(BIT_CYC + 1);
    localparam int unsigned BW       = clog2(DATA_WIDTH + 1);

    localparam parity_e PMODE =
        (PARITY == "EVEN") ? PAR_EVEN :
        (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

    rx_state_e state;
    rx_state_e state_nxt;

    logic                  rxd_s;
    logic                  rxd_prev;
    logic                  fall;
    logic                  edge_pend;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_err;
    logic                  par_calc;
    logic                  tick;
    logic                  cnt_clr;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .arstn(arstn),
        .d    (RXD),
        .q    (rxd_s)
    );

    assign fall = rxd_prev & ~rxd_s;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall || edge_pend) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    tick      = 1'b1;
                    state_nxt = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    tick = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        state_nxt = PARI;
                    end
                end
            end
            PARI: begin
                if (cnt == BIT_LAST) begin
                    tick      = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    tick      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        par_calc = 1'b0;
        unique case (PMODE)
            PAR_EVEN: par_calc = rxd_s != (^shreg);
            PAR_ODD:  par_calc = rxd_s != ~(^shreg);
            default:  par_calc = 1'b0;
        endcase
    end

    assign cnt_clr = (state == IDLE) || (state == DONE) || tick;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == DATA && tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            // LSB arrives first, so after DATA_WIDTH shifts sample k sits in bit k
            if (state == DATA && tick) begin
                shreg <= {rxd_s, shreg[DATA_WIDTH-1:1]};
            end
            if (state == PARI && tick) begin
                par_err <= par_calc;
            end
        end
    end

    // A start edge landing in DONE is remembered and taken in the next IDLE
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rxd_prev  <= 1'b1;
            edge_pend <= 1'b0;
        end else begin
            rxd_prev <= rxd_s;
            if (state == DONE) begin
                edge_pend <= fall;
            end else if (state == IDLE) begin
                edge_pend <= 1'b0;
            end
        end
    end

    // Outputs are loaded on the stop sample so they are visible during DONE
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= (state == STOP) && tick;
            if (state == STOP && tick) begin
                rx_data       <= shreg;
                rx_parity_err <= par_err;
                rx_frame_err  <= ~rxd_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench: three receivers (EVEN, ODD, NONE) on separate lines
// driven with the same frames; captured words are checked in order.
module tb_uart_rx;

    localparam int CF  = 160;
    localparam int BR  = 10;
    localparam int BIT = CF / BR;

    logic       clk   = 1'b0;
    logic       arstn = 1'b0;
    logic [2:0] line  = 3'b111;

    logic [7:0] d_e, d_o, d_n;
    logic       v_e, v_o, v_n;
    logic       pe_e, pe_o, pe_n;
    logic       fe_e, fe_o, fe_n;

    logic [9:0] q_e[$];
    logic [9:0] q_o[$];
    logic [9:0] q_n[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY("EVEN"), .DATA_WIDTH(8)
    ) u_even (
        .clk(clk), .arstn(arstn), .RXD(line[0]), .rx_data(d_e),
        .rx_valid(v_e), .rx_parity_err(pe_e), .rx_frame_err(fe_e)
    );

    uart_rx #(
        .CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY("ODD"), .DATA_WIDTH(8)
    ) u_odd (
        .clk(clk), .arstn(arstn), .RXD(line[1]), .rx_data(d_o),
        .rx_valid(v_o), .rx_parity_err(pe_o), .rx_frame_err(fe_o)
    );

    uart_rx #(
        .CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY("NONE"), .DATA_WIDTH(8)
    ) u_none (
        .clk(clk), .arstn(arstn), .RXD(line[2]), .rx_data(d_n),
        .rx_valid(v_n), .rx_parity_err(pe_n), .rx_frame_err(fe_n)
    );

    always @(negedge clk) begin
        if (v_e) q_e.push_back({fe_e, pe_e, d_e});
        if (v_o) q_o.push_back({fe_o, pe_o, d_o});
        if (v_n) q_n.push_back({fe_n, pe_n, d_n});
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BIT) @(negedge clk);
    endtask

    // correct parity bit per line: {none, odd, even}
    function automatic logic [2:0] good_par(input logic [7:0] d);
        return {1'b0, ~(^d), ^d};
    endfunction

    task automatic drive_frame(input logic [7:0] d, input logic [2:0] par,
                               input logic [2:0] stp);
        line = 3'b000;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            line = {3{d[i]}};
            wait_bits(1);
        end
        line = par;
        wait_bits(1);
        line = stp;
        wait_bits(1);
    endtask

    task automatic clr_q();
        q_e.delete();
        q_o.delete();
        q_n.delete();
    endtask

    task automatic chk_one(input string tag, input logic [9:0] ee,
                           input logic [9:0] eo, input logic [9:0] en);
        chk({tag, "_cnt_even"}, q_e.size(), 1);
        chk({tag, "_cnt_odd"},  q_o.size(), 1);
        chk({tag, "_cnt_none"}, q_n.size(), 1);
        if (q_e.size() > 0) chk({tag, "_even"}, q_e[0], ee);
        if (q_o.size() > 0) chk({tag, "_odd"},  q_o[0], eo);
        if (q_n.size() > 0) chk({tag, "_none"}, q_n[0], en);
        clr_q();
    endtask

    task automatic chk_none(input string tag);
        chk({tag, "_cnt_even"}, q_e.size(), 0);
        chk({tag, "_cnt_odd"},  q_o.size(), 0);
        chk({tag, "_cnt_none"}, q_n.size(), 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_data"},  {d_e, d_o, d_n}, 0);
        chk({tag, "_valid"}, {v_e, v_o, v_n}, 0);
        chk({tag, "_perr"},  {pe_e, pe_o, pe_n}, 0);
        chk({tag, "_ferr"},  {fe_e, fe_o, fe_n}, 0);
    endtask

    initial begin
        #1;
        chk_reset_outs("reset");
        repeat (4) @(negedge clk);
        arstn = 1'b1;
        wait_bits(2);
        chk_none("idle");

        // 0xA5 has four ones: even parity bit 0, odd parity bit 1
        drive_frame(8'hA5, 3'b010, 3'b111);
        wait_bits(2);
        chk_one("a5", 10'h0A5, 10'h0A5, 10'h0A5);

        // parity slot 0 on every line: wrong only for ODD
        drive_frame(8'h3C, 3'b000, 3'b111);
        wait_bits(2);
        chk_one("3c", 10'h03C, 10'h13C, 10'h03C);

        // stop bit low, then line held low for three bit times
        drive_frame(8'h55, 3'b010, 3'b000);
        wait_bits(3);
        chk_one("ferr", 10'h255, 10'h255, 10'h255);
        line = 3'b111;
        wait_bits(2);
        chk_none("ferr_hold");
        drive_frame(8'h81, good_par(8'h81), 3'b111);
        wait_bits(2);
        chk_one("81", 10'h081, 10'h081, 10'h081);

        // low glitch shorter than half a bit
        line = 3'b000;
        repeat (5) @(negedge clk);
        line = 3'b111;
        wait_bits(2);
        chk_none("glitch");
        drive_frame(8'h0F, good_par(8'h0F), 3'b111);
        wait_bits(2);
        chk_one("0f", 10'h00F, 10'h00F, 10'h00F);

        // reset in the middle of data bit 4
        line = 3'b000;
        wait_bits(1);
        line = 3'b111;
        wait_bits(4);
        repeat (BIT / 2) @(negedge clk);
        arstn = 1'b0;
        #1;
        chk_reset_outs("midrst");
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        clr_q();
        wait_bits(3);
        chk_none("midrst_idle");
        drive_frame(8'hC3, good_par(8'hC3), 3'b111);
        wait_bits(2);
        chk_one("c3", 10'h0C3, 10'h0C3, 10'h0C3);

        // back-to-back words with correct parity on every line
        for (int w = 0; w < 256; w++) begin
            drive_frame(8'(w), good_par(8'(w)), 3'b111);
        end
        wait_bits(2);
        chk("b2b_cnt_even", q_e.size(), 256);
        chk("b2b_cnt_odd",  q_o.size(), 256);
        chk("b2b_cnt_none", q_n.size(), 256);
        for (int i = 0; i < 256; i++) begin
            if (i < q_e.size()) chk("b2b_even", q_e[i], {2'b00, 8'(i)});
            if (i < q_o.size()) chk("b2b_odd",  q_o[i], {2'b00, 8'(i)});
            if (i < q_n.size()) chk("b2b_none", q_n[i], {2'b00, 8'(i)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
